// File: rtl/mmio_router.sv
// Routes one core Membus request to RAM, ROM or ACLINT by address window; unmapped gets a local zero reply (optional fault pulse with MMIO_ROUTER_FAULT_EN).
// Mapped: 3 cycles per access with a 1-cycle slave, unmapped: 2; core_ready only in IDLE, downstream valid held until ready.
module mmio_router #(
  parameter logic [63:0] RAM_BASE    = 64'h8000_0000,
  parameter logic [63:0] RAM_SIZE    = 64'h1000_0000,
  parameter logic [63:0] ROM_BASE    = 64'h0000_1000,
  parameter logic [63:0] ROM_SIZE    = 64'h0000_1000,
  parameter logic [63:0] ACLINT_BASE = 64'h0200_0000,
  parameter logic [63:0] ACLINT_SIZE = 64'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        core_valid,
  output logic        core_ready,
  input  logic [63:0] core_addr,
  input  logic        core_wen,
  input  logic [63:0] core_wdata,
  input  logic [7:0]  core_wmask,
  output logic        core_rvalid,
  output logic [63:0] core_rdata,

  output logic        ram_membus_valid,
  input  logic        ram_membus_ready,
  output logic [63:0] ram_membus_addr,
  output logic        ram_membus_wen,
  output logic [63:0] ram_membus_wdata,
  output logic [7:0]  ram_membus_wmask,
  input  logic        ram_membus_rvalid,
  input  logic [63:0] ram_membus_rdata,

  output logic        rom_membus_valid,
  input  logic        rom_membus_ready,
  output logic [63:0] rom_membus_addr,
  output logic        rom_membus_wen,
  output logic [63:0] rom_membus_wdata,
  output logic [7:0]  rom_membus_wmask,
  input  logic        rom_membus_rvalid,
  input  logic [63:0] rom_membus_rdata,

  output logic        aclint_membus_valid,
  input  logic        aclint_membus_ready,
  output logic [63:0] aclint_membus_addr,
  output logic        aclint_membus_wen,
  output logic [63:0] aclint_membus_wdata,
  output logic [7:0]  aclint_membus_wmask,
  input  logic        aclint_membus_rvalid,
  input  logic [63:0] aclint_membus_rdata,

  output logic        fault
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_t;
  typedef enum logic [1:0] {SEL_RAM, SEL_ROM, SEL_ACLINT, SEL_NONE} sel_t;

  localparam logic [63:0] RAM_END    = RAM_BASE + RAM_SIZE;
  localparam logic [63:0] ROM_END    = ROM_BASE + ROM_SIZE;
  localparam logic [63:0] ACLINT_END = ACLINT_BASE + ACLINT_SIZE;

  state_t      state;
  sel_t        sel_q;
  sel_t        dec_sel;
  logic        req_vld;
  logic [63:0] addr_q;
  logic        wen_q;
  logic [63:0] wdata_q;
  logic [7:0]  wmask_q;

  logic        tgt_ready;
  logic        tgt_rvalid;
  logic [63:0] tgt_rdata;

  always_comb begin
    dec_sel = SEL_NONE;
    if (core_addr >= RAM_BASE && core_addr < RAM_END)
      dec_sel = SEL_RAM;
    else if (core_addr >= ROM_BASE && core_addr < ROM_END)
      dec_sel = SEL_ROM;
    else if (core_addr >= ACLINT_BASE && core_addr < ACLINT_END)
      dec_sel = SEL_ACLINT;
  end

  // Only the captured target's handshake and response are ever looked at.
  always_comb begin
    tgt_ready  = 1'b0;
    tgt_rvalid = 1'b0;
    tgt_rdata  = '0;
    case (sel_q)
      SEL_RAM: begin
        tgt_ready  = ram_membus_ready;
        tgt_rvalid = ram_membus_rvalid;
        tgt_rdata  = ram_membus_rdata;
      end
      SEL_ROM: begin
        tgt_ready  = rom_membus_ready;
        tgt_rvalid = rom_membus_rvalid;
        tgt_rdata  = rom_membus_rdata;
      end
      SEL_ACLINT: begin
        tgt_ready  = aclint_membus_ready;
        tgt_rvalid = aclint_membus_rvalid;
        tgt_rdata  = aclint_membus_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      sel_q   <= SEL_NONE;
      req_vld <= 1'b0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (core_valid) begin
            addr_q  <= core_addr;
            wen_q   <= core_wen;
            wdata_q <= core_wdata;
            wmask_q <= core_wmask;
            sel_q   <= dec_sel;
            if (dec_sel == SEL_NONE) begin
              state <= ERR;
            end else begin
              state   <= REQ;
              req_vld <= 1'b1;
            end
          end
        end
        REQ: begin
          if (tgt_ready) begin
            req_vld <= 1'b0;
            state   <= RESP;
          end
        end
        RESP: begin
          if (tgt_rvalid)
            state <= IDLE;
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign core_ready  = (state == IDLE);
  assign core_rvalid = (state == ERR) || ((state == RESP) && tgt_rvalid);
  assign core_rdata  = (state == RESP) ? tgt_rdata : '0;

  assign ram_membus_valid    = req_vld && (sel_q == SEL_RAM);
  assign rom_membus_valid    = req_vld && (sel_q == SEL_ROM);
  assign aclint_membus_valid = req_vld && (sel_q == SEL_ACLINT);

  assign ram_membus_addr     = addr_q;
  assign ram_membus_wen      = wen_q;
  assign ram_membus_wdata    = wdata_q;
  assign ram_membus_wmask    = wmask_q;
  assign rom_membus_addr     = addr_q;
  assign rom_membus_wen      = wen_q;
  assign rom_membus_wdata    = wdata_q;
  assign rom_membus_wmask    = wmask_q;
  assign aclint_membus_addr  = addr_q;
  assign aclint_membus_wen   = wen_q;
  assign aclint_membus_wdata = wdata_q;
  assign aclint_membus_wmask = wmask_q;

`ifdef MMIO_ROUTER_FAULT_EN
  logic fault_q;

  // Set on the accepting edge so the pulse lines up with the ERR-state rvalid.
  always_ff @(posedge clk) begin
    if (!rst)
      fault_q <= 1'b0;
    else
      fault_q <= core_ready && core_valid && (dec_sel == SEL_NONE);
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule

// File: doc/mmio_router.md
# mmio_router

Core-facing memory-mapped I/O router that sits directly upstream of the RAM, ROM and ACLINT slave ports. It accepts one `Membus` request at a time from the core's data side and decodes its address against three fixed windows. It forwards the registered request to exactly one downstream slave and returns that slave's response to the core. Unmapped addresses get a locally generated zero response. At most one transaction is outstanding.

## Interface

Parameters:
- `RAM_BASE`, 64'h8000_0000: RAM window base.
- `RAM_SIZE`, 64'h1000_0000: RAM window size in bytes.
- `ROM_BASE`, 64'h0000_1000: ROM window base.
- `ROM_SIZE`, 64'h0000_1000: ROM window size in bytes.
- `ACLINT_BASE`, 64'h0200_0000: ACLINT window base.
- `ACLINT_SIZE`, 64'h0001_0000: ACLINT window size in bytes.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-low.
- `core`  Membus.slave  —  upstream request/response from the core (valid, ready, addr, wen, wdata, wmask, rvalid, rdata).
- `ram_membus`  Membus.master  —  to the RAM slave.
- `rom_membus`  Membus.master  —  to the ROM slave.
- `aclint_membus`  Membus.master  —  to the ACLINT slave.
- `fault`  out  1  one-cycle pulse on an unmapped access. Tied 0 unless `MMIO_ROUTER_FAULT_EN` is defined.

## Operation

- Decode: a window hits when `BASE <= addr < BASE+SIZE`, computed with full-XLEN unsigned compare. Windows do not overlap, so priority does not matter. An address that hits no window is unmapped.
- The router captures the request into registers on `core.valid && core.ready`: addr, wen, wdata, wmask and target select. The full address passes downstream unmodified; downstream slaves decode absolute addresses.
- States:
  - **IDLE**: `core.ready`=1. On acceptance, go to REQ for a mapped address, or ERR for an unmapped one.
  - **REQ**: the selected target's `valid`=1 with the captured fields; all other targets' `valid`=0. On target `ready`=1, go to RESP. Otherwise hold REQ with the fields stable.
  - **RESP**: `core.rvalid` = selected target `rvalid`, and `core.rdata` = selected target `rdata`, both combinational. On target `rvalid`=1, go to IDLE.
  - **ERR**: `core.rvalid`=1, `core.rdata`=0. Writes are dropped. `fault` pulses if enabled. Next state is IDLE.
- `core.ready`=0 in every state except IDLE.
- Writes also complete through RESP/ERR, because slaves return `rvalid` for writes too. The core sees `rvalid` for every accepted request.
- A target `rvalid` outside RESP, or from a non-selected target, is ignored.
- Downstream `wdata`/`wmask` are presented unmodified; byte masking belongs to the slave.

## Timing

- Reset (`rst`=0 at a `clk` edge) sets:
  - state = IDLE;
  - all downstream `valid`=0;
  - `core.rvalid`=0 and `core.rdata`=0;
  - `fault`=0;
  - captured registers cleared.
- Reset mid-transaction abandons it. A late slave `rvalid` after reset is ignored.
- Latency with a slave that has `ready`=1 and 1-cycle `rvalid`, request accepted in cycle 0:
  - downstream `valid` is high in cycle 1;
  - `core.rvalid` is high in cycle 2;
  - the next acceptance can happen in cycle 3.
- Unmapped access accepted in cycle 0: `core.rvalid` (and `fault`) is high in cycle 1, and the next acceptance can happen in cycle 2.
- Back-to-back throughput is one transaction per 3 cycles for mapped accesses and per 2 cycles for unmapped accesses.
- Downstream `valid` is held until `ready`, and the fields do not change while waiting.
- A boundary address `BASE+SIZE` is unmapped unless another window starts there. `BASE+SIZE` must not overflow 64 bits; this is a parameter restriction.

## Configuration

- `MMIO_ROUTER_FAULT_EN` defined: `fault` is a registered one-cycle pulse, coincident with the ERR-state `rvalid`, for each unmapped access.
- `MMIO_ROUTER_FAULT_EN` not defined: `fault` is constant 0, and unmapped accesses silently read 0 and drop writes. Response timing is identical in both builds.

## Test plan

- ACLINT MSIP write then read-back:
  - write addr 0x0200_0000, wdata 1, full wmask → `aclint_membus.valid` for exactly one cycle, then `core.rvalid` 2 cycles after acceptance;
  - read the same address → `core.rdata`=1;
  - other targets' `valid` stay 0 throughout.
- RAM read with a stalled slave: addr 0x8000_0010, RAM `ready` held 0 for 3 cycles → `ram_membus.valid` and addr stay stable for 4 cycles, `core.ready`=0, and `core.rdata` equals the RAM data when RAM `rvalid` arrives.
- Unmapped read at 0x4000_0000 → `core.rvalid`=1 with rdata=0 one cycle after acceptance, no downstream `valid`, and `fault`=1 for one cycle (0 in a build without the macro).
- Window edges:
  - 0x0000_1FFF → ROM;
  - 0x0000_2000 → unmapped;
  - 0x0200_FFFF → ACLINT;
  - 0x7FFF_FFFF → unmapped.
- Reset mid-transaction: `rst`=0 while in RESP, and the RAM `rvalid` arrives one cycle after reset release → no `core.rvalid`, and `core.ready`=1 the first cycle after reset release.
